funct_fact: RTL and testbench



---
 rtl/funct_fact.sv | 96 +++++++++
 tb/tb_funct_fact.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/funct_fact.sv
// Registered factorial unit: result = n! mod 2**RESULT_W, one operand per cycle, 1-cycle latency.
// Optional build macro FUNCT_FACT_SAT_EN adds the ovf port and saturates result to all ones when n! overflows.
module funct_fact #(
  parameter int N_W      = 4,
  parameter int RESULT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_W-1:0]      n,
  output logic [RESULT_W-1:0] result
`ifdef FUNCT_FACT_SAT_EN
  ,
  output logic                ovf
`endif
);

  typedef struct packed {
    logic                ovf;
    logic [RESULT_W-1:0] val;
  } fact_t;

  localparam int ROM_DEPTH = 2 ** N_W;

  // Truncated product chain; the overflow flag is sticky once any partial
  // product spills past RESULT_W bits, so it marks fact(k) >= 2**RESULT_W.
  function automatic fact_t fact_calc(input int k);
    fact_t                 r;
    logic [2*RESULT_W-1:0] prod;
    r.ovf = 1'b0;
    r.val = RESULT_W'(1);
    for (int i = 2; i <= k; i++) begin
      prod  = {{RESULT_W{1'b0}}, r.val} * (2*RESULT_W)'(i);
      r.val = prod[RESULT_W-1:0];
      r.ovf = r.ovf | (|prod[2*RESULT_W-1:RESULT_W]);
    end
    return r;
  endfunction

  // NOTE: the table is pure constants folded at elaboration; it has no state,
  // so it needs no reset -- only the output registers do.
  fact_t rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    assign rom[g] = fact_calc(g);
  end

  fact_t               entry;
  logic [RESULT_W-1:0] result_d, result_q;

`ifdef FUNCT_FACT_SAT_EN
  logic ovf_d, ovf_q;

  always_comb begin
    entry    = rom[n];
    result_d = entry.val;
    ovf_d    = entry.ovf;
    if (entry.ovf) begin
      result_d = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;

  always_comb begin
    entry    = rom[n];
    result_d = entry.val;
  end

  assign unused_ovf = entry.ovf;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end
`endif

  assign result = result_q;

endmodule

// File: tb/tb_funct_fact.sv
// Self-checking bench for funct_fact: vector table, reset corner sequences and a random stream.
// Honours FUNCT_FACT_SAT_EN the same way as the design.
module tb_funct_fact;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  n;
  logic [31:0] result;
`ifdef FUNCT_FACT_SAT_EN
  logic        ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  funct_fact #(.N_W(4), .RESULT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .n      (n),
    .result (result)
`ifdef FUNCT_FACT_SAT_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] result;
    logic        ovf;
  } vec_t;

  logic [31:0] fact_ref [16];
  vec_t        vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_result(input logic [3:0] k);
`ifdef FUNCT_FACT_SAT_EN
    if (k >= 4'd13) return 32'hFFFF_FFFF;
`endif
    return fact_ref[k];
  endfunction

  initial begin
    fact_ref = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040,
                 32'd40320, 32'd362880, 32'd3628800, 32'd39916800, 32'd479001600,
                 32'd1932053504, 32'd1278945280, 32'd2004310016};

    // Consecutive 0..5 first (latency/no-bubble), then the rest incl. wrap/saturation boundary.
    vecs[0]  = '{4'd0,  32'd1,         1'b0};
    vecs[1]  = '{4'd1,  32'd1,         1'b0};
    vecs[2]  = '{4'd2,  32'd2,         1'b0};
    vecs[3]  = '{4'd3,  32'd6,         1'b0};
    vecs[4]  = '{4'd4,  32'd24,        1'b0};
    vecs[5]  = '{4'd5,  32'd120,       1'b0};
    vecs[6]  = '{4'd6,  32'd720,       1'b0};
    vecs[7]  = '{4'd8,  32'd40320,     1'b0};
    vecs[8]  = '{4'd9,  32'd362880,    1'b0};
    vecs[9]  = '{4'd10, 32'd3628800,   1'b0};
    vecs[10] = '{4'd11, 32'd39916800,  1'b0};
    vecs[11] = '{4'd12, 32'd479001600, 1'b0};
`ifdef FUNCT_FACT_SAT_EN
    vecs[12] = '{4'd13, 32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{4'd14, 32'hFFFF_FFFF, 1'b1};
    vecs[14] = '{4'd15, 32'hFFFF_FFFF, 1'b1};
`else
    vecs[12] = '{4'd13, 32'd1932053504, 1'b0};
    vecs[13] = '{4'd14, 32'd1278945280, 1'b0};
    vecs[14] = '{4'd15, 32'd2004310016, 1'b0};
`endif
    vecs[15] = '{4'd7,  32'd5040,      1'b0};

    // Reset held: n swept, result must stay 0.
    reset = 1'b1;
    n     = 4'd0;
    #1;
    check("reset_initial", result, 32'd0);
    for (int i = 0; i < 16; i++) begin
      n = 4'(i);
      tick();
      check($sformatf("reset_hold_n%0d", i), result, 32'd0);
`ifdef FUNCT_FACT_SAT_EN
      check($sformatf("reset_hold_ovf_n%0d", i), 32'(ovf), 32'd0);
`endif
    end

    // Release mid-cycle, then apply the vector table one operand per edge.
    #2 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n = vecs[i].n;
      tick();
      check($sformatf("vec%0d_n%0d", i, vecs[i].n), result, vecs[i].result);
`ifdef FUNCT_FACT_SAT_EN
      check($sformatf("vec%0d_ovf_n%0d", i, vecs[i].n), 32'(ovf), 32'(vecs[i].ovf));
`endif
    end

    // n=7 held: stable result, then async reset mid-cycle, then recovery.
    n = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold7_cycle%0d", i), result, 32'd5040);
    end
    #3 reset = 1'b1;
    #1;
    check("async_reset_clear", result, 32'd0);
`ifdef FUNCT_FACT_SAT_EN
    check("async_reset_ovf", 32'(ovf), 32'd0);
`endif
    tick();
    check("reset_mid_hold", result, 32'd0);
    #2 reset = 1'b0;
    tick();
    check("post_reset_reload", result, 32'd5040);

    // Async clear from a saturating/wrapping value, then first edge after release.
    n = 4'd15;
    tick();
    check("pre_reset_n15", result, exp_result(4'd15));
    #2 reset = 1'b1;
    #1;
    check("async_reset_from_n15", result, 32'd0);
    #2 reset = 1'b0;
    n = 4'd3;
    tick();
    check("post_reset_n3", result, 32'd6);

    // Random stream: each result reflects the n sampled at the preceding edge.
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] nr;
      nr = 4'($urandom_range(0, 15));
      n  = nr;
      tick();
      check($sformatf("rand%0d_n%0d", i, nr), result, exp_result(nr));
`ifdef FUNCT_FACT_SAT_EN
      check($sformatf("rand%0d_ovf_n%0d", i, nr), 32'(ovf), (nr >= 4'd13) ? 32'd1 : 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
